alu_divider: RTL and testbench

//  Multi-cycle non-restoring 32-bit divider for the ALU's DIV path. Sits directly upstream of the

---
 rtl/alu_divider_pkg.sv | 19 +
 rtl/alu_divider_sign_fix.sv | 19 +
 rtl/alu_divider.sv | 168 ++++++++++++++++
 tb/tb_alu_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_divider_pkg.sv
// Shared types and constants for the multi-cycle non-restoring divider.
// Imported by alu_divider and div_sign_fix.
package alu_div_pkg;

   localparam int DIV_WIDTH   = 32;
   localparam int DIV_ITERS   = 32;
   localparam int DIV_LATENCY = 36;
   localparam int DIV_CNT_W   = $clog2(DIV_ITERS);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ITER,
      CORRECT,
      FIXUP,
      DONE
   } div_state_t;

endpackage

// File: rtl/alu_divider_sign_fix.sv
// Combinational two-lane conditional negation: magnitude extraction on the way in,
// sign restoration of quotient/remainder on the way out.
module div_sign_fix
   import alu_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic             neg_a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             neg_b_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o
);

   assign a_o = neg_a_i ? -a_i : a_i;
   assign b_o = neg_b_i ? -b_i : b_i;

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle non-restoring 32-bit divider driving the shared external adder via add_*.
// Define ALU_DIV_SIGNED_EN to add the is_signed port and two's-complement division.
module alu_divider
   import alu_div_pkg::*;
#(
   parameter int                WIDTH    = DIV_WIDTH,
   parameter logic [WIDTH-1:0]  DBZ_QUOT = '1
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef ALU_DIV_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] add_x,
   output logic [WIDTH-1:0] add_y,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output div_state_t       dbg_state
);

   // Handshake: start is honoured only while IDLE; done pulses once with results,
   // which then stay on quotient/remainder until the next accepted request finishes.

   div_state_t             state_q, state_d;
   logic [WIDTH-1:0]       dvd_q, dvs_q;
   logic                   sgn_q;
   logic [WIDTH:0]         a_q;
   logic [WIDTH-1:0]       q_q, d_q;
   logic [DIV_CNT_W-1:0]   cnt_q;
   logic                   quo_neg_q, rem_neg_q;
   logic [WIDTH-1:0]       quotient_q, remainder_q;
   logic                   dbz_q;

   logic                   signed_req;
   logic [WIDTH:0]         a_sh;
   logic                   sub;
   logic                   a_new_sign;
   logic [WIDTH-1:0]       mag_dvd, mag_dvs, fix_quo, fix_rem;

`ifdef ALU_DIV_SIGNED_EN
   assign signed_req = is_signed;
`else
   assign signed_req = 1'b0;
`endif

   assign a_sh       = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign sub        = ~a_q[WIDTH];
   // Bit 32 of the 33-bit partial remainder is rebuilt from the 32-bit adder's carry.
   assign a_new_sign = a_sh[WIDTH] ^ sub ^ add_cout;

   div_sign_fix #(.WIDTH(WIDTH)) u_mag (
      .a_i     (dvd_q),
      .neg_a_i (sgn_q & dvd_q[WIDTH-1]),
      .b_i     (dvs_q),
      .neg_b_i (sgn_q & dvs_q[WIDTH-1]),
      .a_o     (mag_dvd),
      .b_o     (mag_dvs)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_fix (
      .a_i     (q_q),
      .neg_a_i (quo_neg_q),
      .b_i     (a_q[WIDTH-1:0]),
      .neg_b_i (rem_neg_q),
      .a_o     (fix_quo),
      .b_o     (fix_rem)
   );

   always_comb begin
      state_d = state_q;
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = SETUP;
         SETUP:   state_d = (dvs_q == '0) ? DONE : ITER;
         ITER: begin
            add_x   = a_sh[WIDTH-1:0];
            add_y   = sub ? ~d_q : d_q;
            add_cin = sub;
            if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) state_d = CORRECT;
         end
         CORRECT: begin
            if (a_q[WIDTH]) begin
               add_x = a_q[WIDTH-1:0];
               add_y = d_q;
            end
            state_d = FIXUP;
         end
         FIXUP:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q     <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         sgn_q       <= 1'b0;
         a_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         quo_neg_q   <= 1'b0;
         rem_neg_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
                  sgn_q <= signed_req;
               end
            end
            SETUP: begin
               q_q       <= mag_dvd;
               d_q       <= mag_dvs;
               a_q       <= '0;
               cnt_q     <= '0;
               quo_neg_q <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
               rem_neg_q <= sgn_q & dvd_q[WIDTH-1];
               if (dvs_q == '0) begin
                  quotient_q  <= DBZ_QUOT;
                  remainder_q <= dvd_q;
                  dbz_q       <= 1'b1;
               end
            end
            ITER: begin
               a_q   <= {a_new_sign, add_sum};
               q_q   <= {q_q[WIDTH-2:0], ~a_new_sign};
               cnt_q <= cnt_q + 1'b1;
            end
            CORRECT: begin
               if (a_q[WIDTH]) a_q <= {1'b0, add_sum};
            end
            FIXUP: begin
               quotient_q  <= fix_quo;
               remainder_q <= fix_rem;
               dbz_q       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider with a behavioural 32-bit adder on the add_* ports.
module tb_alu_divider;
   import alu_div_pkg::*;

   localparam int W = DIV_WIDTH;

   logic         clk = 1'b0;
   logic         nRst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         is_signed = 1'b0;
   logic         busy, done, div_by_zero, add_cin, add_cout;
   logic [W-1:0] quotient, remainder, add_x, add_y, add_sum;
   div_state_t   dbg_state;

   alu_divider dut (
      .clk         (clk),
      .nRst        (nRst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef ALU_DIV_SIGNED_EN
      .is_signed   (is_signed),
`endif
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .quotient    (quotient),
      .remainder   (remainder),
      .add_x       (add_x),
      .add_y       (add_y),
      .add_cin     (add_cin),
      .add_sum     (add_sum),
      .add_cout    (add_cout),
      .dbg_state   (dbg_state)
   );

   assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // scoreboard
   int checks = 0;
   int failures = 0;
   logic [2*W:0] exp_q[$];
   int           cyc_q[$];
   int           lat_q[$];
   int           busy_run = 0;
   logic [2*W:0] e;
   int           exp_cyc, exp_lat;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (busy) busy_run++;
      else busy_run = 0;
      if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            e       = exp_q.pop_front();
            exp_cyc = cyc_q.pop_front();
            exp_lat = lat_q.pop_front();
            check("quotient", quotient, e[2*W-1:W]);
            check("remainder", remainder, e[W-1:0]);
            check("div_by_zero", W'(div_by_zero), W'(e[2*W]));
            check("done_latency", W'(cyc), W'(exp_cyc));
            check("busy_span", W'(busy_run), W'(exp_lat));
         end
      end
   end

   // driver tasks
   task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
      int lat;
      @(negedge clk);
      dividend  = dvd;
      divisor   = dvs;
      is_signed = sgn;
      start     = 1'b1;
      lat       = edbz ? 2 : DIV_LATENCY;
      exp_q.push_back({edbz, eq, er});
      cyc_q.push_back(cyc + lat);
      lat_q.push_back(lat);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
         exp_q.delete();
         cyc_q.delete();
         lat_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_done"}, W'(done), '0);
      check({tag, "_busy"}, W'(busy), '0);
      check({tag, "_dbz"}, W'(div_by_zero), '0);
      check({tag, "_quotient"}, quotient, '0);
      check({tag, "_remainder"}, remainder, '0);
      check({tag, "_add_x"}, add_x, '0);
      check({tag, "_add_y"}, add_y, '0);
      check({tag, "_add_cin"}, W'(add_cin), '0);
      check({tag, "_state"}, W'(dbg_state), W'(IDLE));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      nRst = 1'b1;
      repeat (2) @(negedge clk);

      // basic unsigned, then result held after done
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      wait_drain();
      repeat (3) @(negedge clk);
      check("held_quotient", quotient, 32'd14);
      check("held_remainder", remainder, 32'd2);

      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
      wait_drain();
      issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
      wait_drain();
      issue(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0);
      wait_drain();
      issue(32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0);
      wait_drain();
      issue(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
      wait_drain();

      // divide by zero
      issue(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
      wait_drain();

`ifdef ALU_DIV_SIGNED_EN
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      wait_drain();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
      wait_drain();
      issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
      wait_drain();
`endif

      // start re-pulsed while busy must be ignored
      issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
      repeat (3) @(negedge clk);
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      dividend = 32'd60;
      divisor  = 32'd0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain();

      // reset mid-operation aborts without a done
      issue(32'd77, 32'd7, 1'b0, 32'd11, 32'd0, 1'b0);
      repeat (13) @(negedge clk);
      exp_q.delete();
      cyc_q.delete();
      lat_q.delete();
      nRst = 1'b0;
      @(posedge clk);
      #2;
      check_all_zero("abort");
      @(negedge clk);
      nRst = 1'b1;
      repeat (40) @(negedge clk);
      issue(32'h1234_5678, 32'h100, 1'b0, 32'h0012_3456, 32'h78, 1'b0);
      wait_drain();

      repeat (40) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
